// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default widths, command encodings,
// operand-qualifier encodings and the result/flags record.
package alu_pkg;

  localparam int ALU_WIDTH     = 8;
  localparam int ALU_CMD_WIDTH = 4;

  // Arithmetic command set (MODE = 1); 13..15 are illegal.
  typedef enum logic [3:0] {
    ARITH_ADD     = 4'd0,
    ARITH_SUB     = 4'd1,
    ARITH_ADD_CIN = 4'd2,
    ARITH_SUB_CIN = 4'd3,
    ARITH_INC_A   = 4'd4,
    ARITH_DEC_A   = 4'd5,
    ARITH_INC_B   = 4'd6,
    ARITH_DEC_B   = 4'd7,
    ARITH_CMP     = 4'd8,
    ARITH_MUL_INC = 4'd9,
    ARITH_MUL_SHL = 4'd10,
    ARITH_SADD    = 4'd11,
    ARITH_SSUB    = 4'd12
  } arith_cmd_e;

  // Logical command set (MODE = 0); 14..15 are illegal.
  typedef enum logic [3:0] {
    LOGIC_AND     = 4'd0,
    LOGIC_NAND    = 4'd1,
    LOGIC_OR      = 4'd2,
    LOGIC_NOR     = 4'd3,
    LOGIC_XOR     = 4'd4,
    LOGIC_XNOR    = 4'd5,
    LOGIC_NOT_A   = 4'd6,
    LOGIC_NOT_B   = 4'd7,
    LOGIC_SHR1_A  = 4'd8,
    LOGIC_SHL1_A  = 4'd9,
    LOGIC_SHR1_B  = 4'd10,
    LOGIC_SHL1_B  = 4'd11,
    LOGIC_ROL_A_B = 4'd12,
    LOGIC_ROR_A_B = 4'd13
  } logic_cmd_e;

  // INP_VALID encodings: bit0 qualifies OPA, bit1 qualifies OPB.
  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

  // Status flags, ordered as they appear on the port list.
  typedef struct packed {
    logic cout;
    logic oflow;
    logic g;
    logic e;
    logic l;
    logic err;
  } alu_flags_t;

  // Full output record at the default width.
  typedef struct packed {
    logic [2*ALU_WIDTH-1:0] res;
    alu_flags_t             flags;
  } alu_out_t;

endpackage

// File: rtl/alu_mul_stage.sv
// One-stage registered multiplier. Holds the product of a multiply command
// (or an error record when operands were missing) for one enabled cycle.
module alu_mul_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               shl_sel,
  input  logic               err_in,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               pending,
  output logic [2*WIDTH-1:0] res,
  output alu_flags_t         flags
);
  localparam int RW = 2 * WIDTH;
  localparam logic [RW-1:0] ONE = RW'(1);

  logic [RW-1:0] mul_a;
  logic [RW-1:0] mul_b;
  logic          valid_q, valid_d;
  logic [RW-1:0] res_q, res_d;
  logic          err_q, err_d;

  // Operand shaping and product; the product wraps at 2*WIDTH bits.
  always_comb begin
    mul_a   = RW'(opa) + ONE;
    mul_b   = RW'(opb) + ONE;
    if (shl_sel) begin
      mul_a = RW'({opa[WIDTH-2:0], 1'b0});
      mul_b = RW'(opb);
    end
    valid_d = start;
    err_d   = err_in;
    res_d   = err_in ? '0 : (mul_a * mul_b);
  end

  // Pending-product register; frozen while the clock enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Multiplies define no flags other than the error flag.
  always_comb begin
    flags     = '0;
    flags.err = err_q;
  end

  assign pending = valid_q;
  assign res     = res_q;

endmodule

// File: rtl/alu_design.sv
// Clocked integer ALU: combinational decode/compute, a one-stage multiply
// path and a single output register. A non-multiply result that collides
// with a completing multiply is parked for one cycle so results leave in
// command order.
module alu_design
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int CMD_WIDTH = ALU_CMD_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 MODE,
  input  logic [CMD_WIDTH-1:0] CMD,
  input  logic [1:0]           INP_VALID,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic                 CIN,
  output logic [2*WIDTH-1:0]   RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 G,
  output logic                 E,
  output logic                 L,
  output logic                 ERR
);
  localparam int RW  = 2 * WIDTH;
  localparam int SHW = $clog2(WIDTH);
  localparam logic [RW-1:0]  ONE   = RW'(1);
  localparam logic [SHW:0]   ROT_W = (SHW + 1)'(WIDTH);

  logic [3:0]       cmd_lo;
  logic             cmd_hi;
  logic             need_a, need_b, legal, is_mul, operands_ok;
  logic [RW-1:0]    a_ext, b_ext, res_c;
  logic [WIDTH:0]   sa, sb, ssum;
  logic [WIDTH-1:0] lg;
  logic [SHW-1:0]   rot_amt;
  logic             rot_range_err;
  alu_flags_t       flags_c;

  logic             mul_pending;
  logic [RW-1:0]    mul_res;
  alu_flags_t       mul_flags;

  logic [RW-1:0]    res_q, res_d;
  alu_flags_t       flags_q, flags_d;
  logic             defer_valid_q, defer_valid_d;
  logic [RW-1:0]    defer_res_q, defer_res_d;
  alu_flags_t       defer_flags_q, defer_flags_d;

  generate
    if (CMD_WIDTH > 4) begin : g_cmd_hi
      assign cmd_hi = |CMD[CMD_WIDTH-1:4];
    end else begin : g_cmd_narrow
      assign cmd_hi = 1'b0;
    end
  endgenerate
  assign cmd_lo = CMD[3:0];

  // Command legality, operand requirements and multiply detection.
  always_comb begin
    need_a = 1'b1;
    need_b = 1'b1;
    legal  = ~cmd_hi;
    is_mul = 1'b0;
    if (MODE) begin
      case (cmd_lo)
        ARITH_INC_A, ARITH_DEC_A:     need_b = 1'b0;
        ARITH_INC_B, ARITH_DEC_B:     need_a = 1'b0;
        ARITH_MUL_INC, ARITH_MUL_SHL: is_mul = ~cmd_hi;
        ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN, ARITH_SUB_CIN,
        ARITH_CMP, ARITH_SADD, ARITH_SSUB: ;
        default:                      legal = 1'b0;
      endcase
    end else begin
      case (cmd_lo)
        LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A: need_b = 1'b0;
        LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B: need_a = 1'b0;
        LOGIC_AND, LOGIC_NAND, LOGIC_OR, LOGIC_NOR, LOGIC_XOR,
        LOGIC_XNOR, LOGIC_ROL_A_B, LOGIC_ROR_A_B: ;
        default:                                 legal = 1'b0;
      endcase
    end
    operands_ok = (~need_a | INP_VALID[0]) & (~need_b | INP_VALID[1]);
  end

  // Single-cycle result and flags for every non-multiply command.
  always_comb begin
    res_c         = '0;
    lg            = '0;
    flags_c       = '0;
    ssum          = '0;
    a_ext         = RW'(OPA);
    b_ext         = RW'(OPB);
    sa            = {OPA[WIDTH-1], OPA};
    sb            = {OPB[WIDTH-1], OPB};
    rot_amt       = OPB[SHW-1:0];
    rot_range_err = |(OPB >> SHW);
    if (MODE) begin
      case (cmd_lo)
        ARITH_ADD:     begin res_c = a_ext + b_ext;              flags_c.cout  = res_c[WIDTH]; end
        ARITH_SUB:     begin res_c = a_ext - b_ext;              flags_c.oflow = (OPA < OPB); end
        ARITH_ADD_CIN: begin res_c = a_ext + b_ext + RW'(CIN);   flags_c.cout  = res_c[WIDTH]; end
        ARITH_SUB_CIN: begin res_c = a_ext - b_ext - RW'(CIN);   flags_c.oflow = (a_ext < b_ext + RW'(CIN)); end
        ARITH_INC_A:   begin res_c = a_ext + ONE;                flags_c.cout  = res_c[WIDTH]; end
        ARITH_DEC_A:   begin res_c = a_ext - ONE;                flags_c.oflow = (OPA == '0); end
        ARITH_INC_B:   begin res_c = b_ext + ONE;                flags_c.cout  = res_c[WIDTH]; end
        ARITH_DEC_B:   begin res_c = b_ext - ONE;                flags_c.oflow = (OPB == '0); end
        ARITH_CMP: begin
          flags_c.g = (OPA > OPB);
          flags_c.e = (OPA == OPB);
          flags_c.l = (OPA < OPB);
        end
        // Signed ops keep the WIDTH+1-bit sum; carry is not defined for them.
        ARITH_SADD: begin
          ssum          = sa + sb;
          res_c         = RW'(ssum);
          flags_c.oflow = (OPA[WIDTH-1] == OPB[WIDTH-1]) && (ssum[WIDTH-1] != OPA[WIDTH-1]);
          flags_c.g     = ($signed(OPA) > $signed(OPB));
          flags_c.e     = (OPA == OPB);
          flags_c.l     = ($signed(OPA) < $signed(OPB));
        end
        ARITH_SSUB: begin
          ssum          = sa - sb;
          res_c         = RW'(ssum);
          flags_c.oflow = (OPA[WIDTH-1] != OPB[WIDTH-1]) && (ssum[WIDTH-1] != OPA[WIDTH-1]);
          flags_c.g     = ($signed(OPA) > $signed(OPB));
          flags_c.e     = (OPA == OPB);
          flags_c.l     = ($signed(OPA) < $signed(OPB));
        end
        default: ;
      endcase
    end else begin
      case (cmd_lo)
        LOGIC_AND:     lg = OPA & OPB;
        LOGIC_NAND:    lg = ~(OPA & OPB);
        LOGIC_OR:      lg = OPA | OPB;
        LOGIC_NOR:     lg = ~(OPA | OPB);
        LOGIC_XOR:     lg = OPA ^ OPB;
        LOGIC_XNOR:    lg = ~(OPA ^ OPB);
        LOGIC_NOT_A:   lg = ~OPA;
        LOGIC_NOT_B:   lg = ~OPB;
        LOGIC_SHR1_A:  lg = OPA >> 1;
        LOGIC_SHL1_A:  lg = OPA << 1;
        LOGIC_SHR1_B:  lg = OPB >> 1;
        LOGIC_SHL1_B:  lg = OPB << 1;
        // Out-of-range rotate amount flags ERR but still delivers the rotation.
        LOGIC_ROL_A_B: begin
          lg          = (OPA << rot_amt) | (OPA >> (ROT_W - {1'b0, rot_amt}));
          flags_c.err = rot_range_err;
        end
        LOGIC_ROR_A_B: begin
          lg          = (OPA >> rot_amt) | (OPA << (ROT_W - {1'b0, rot_amt}));
          flags_c.err = rot_range_err;
        end
        default: ;
      endcase
      res_c = RW'(lg);
    end
    if (!legal || !operands_ok) begin
      res_c       = '0;
      flags_c     = '0;
      flags_c.err = 1'b1;
    end
  end

  alu_mul_stage #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .rst     (RST),
    .en      (CE),
    .start   (is_mul),
    .shl_sel (cmd_lo == ARITH_MUL_SHL),
    .err_in  (~operands_ok),
    .opa     (OPA),
    .opb     (OPB),
    .pending (mul_pending),
    .res     (mul_res),
    .flags   (mul_flags)
  );

  // Output selection: a finishing multiply wins; a parked result goes next;
  // a fresh non-multiply result is parked whenever the output is taken.
  always_comb begin
    res_d         = res_q;
    flags_d       = flags_q;
    defer_valid_d = 1'b0;
    defer_res_d   = defer_res_q;
    defer_flags_d = defer_flags_q;
    if (mul_pending || defer_valid_q) begin
      res_d   = mul_pending ? mul_res   : defer_res_q;
      flags_d = mul_pending ? mul_flags : defer_flags_q;
      if (!is_mul) begin
        defer_valid_d = 1'b1;
        defer_res_d   = res_c;
        defer_flags_d = flags_c;
      end
    end else if (!is_mul) begin
      res_d   = res_c;
      flags_d = flags_c;
    end
  end

  // Output and parking registers; reset overrides the clock enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_q         <= '0;
      flags_q       <= '0;
      defer_valid_q <= 1'b0;
      defer_res_q   <= '0;
      defer_flags_q <= '0;
    end else if (CE) begin
      res_q         <= res_d;
      flags_q       <= flags_d;
      defer_valid_q <= defer_valid_d;
      defer_res_q   <= defer_res_d;
      defer_flags_q <= defer_flags_d;
    end
  end

  assign RES   = res_q;
  assign COUT  = flags_q.cout;
  assign OFLOW = flags_q.oflow;
  assign G     = flags_q.g;
  assign E     = flags_q.e;
  assign L     = flags_q.l;
  assign ERR   = flags_q.err;

endmodule

// File: tb/tb_alu_design.sv
// Self-checking bench for alu_design: directed cases with constant
// expectations, then randomized traffic against a behavioural model that
// schedules each command's result by its latency, in command order.
module tb_alu_design;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        RST, CE, MODE, CIN;
  logic [3:0]  CMD;
  logic [1:0]  INP_VALID;
  logic [7:0]  OPA, OPB;
  logic [15:0] RES;
  logic        COUT, OFLOW, G, E, L, ERR;

  int n_checks = 0;
  int n_errors = 0;
  int txn      = 0;

  typedef struct {
    int       due;
    alu_out_t o;
  } pend_t;

  pend_t    pend[$];
  alu_out_t exp_out = '0;
  int       edge_k  = 0;
  int       last_due = 0;

  alu_design dut (
    .CLK(clk), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD),
    .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB), .CIN(CIN),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Result of one command computed from the command table with plain integers.
  function automatic alu_out_t ref_model(bit mode, int cmd, bit [1:0] iv, int a, int b, bit cin);
    alu_out_t o;
    int r, sa, sb, sh;
    bit need_a, need_b, legal;
    o = '0; r = 0; need_a = 1; need_b = 1; legal = 1;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    if (mode) begin
      case (cmd)
        0:  begin r = a + b;              o.flags.cout  = (r > 255); end
        1:  begin r = a - b;              o.flags.oflow = (r < 0); end
        2:  begin r = a + b + int'(cin);  o.flags.cout  = (r > 255); end
        3:  begin r = a - b - int'(cin);  o.flags.oflow = (r < 0); end
        4:  begin need_b = 0; r = a + 1;  o.flags.cout  = (r > 255); end
        5:  begin need_b = 0; r = a - 1;  o.flags.oflow = (r < 0); end
        6:  begin need_a = 0; r = b + 1;  o.flags.cout  = (r > 255); end
        7:  begin need_a = 0; r = b - 1;  o.flags.oflow = (r < 0); end
        8:  begin o.flags.g = (a > b); o.flags.e = (a == b); o.flags.l = (a < b); end
        9:  r = (a + 1) * (b + 1);
        10: r = ((a * 2) % 256) * b;
        11, 12: begin
          r = (cmd == 11) ? sa + sb : sa - sb;
          o.flags.oflow = (r > 127) || (r < -128);
          o.flags.g = (sa > sb); o.flags.e = (sa == sb); o.flags.l = (sa < sb);
          r = r & 32'h1FF;
        end
        default: legal = 0;
      endcase
    end else begin
      case (cmd)
        0:  r = a & b;
        1:  r = ~(a & b) & 255;
        2:  r = a | b;
        3:  r = ~(a | b) & 255;
        4:  r = a ^ b;
        5:  r = ~(a ^ b) & 255;
        6:  begin need_b = 0; r = ~a & 255; end
        7:  begin need_a = 0; r = ~b & 255; end
        8:  begin need_b = 0; r = a / 2; end
        9:  begin need_b = 0; r = (a * 2) % 256; end
        10: begin need_a = 0; r = b / 2; end
        11: begin need_a = 0; r = (b * 2) % 256; end
        12: begin r = ((a << sh) | (a >> (8 - sh))) & 255; o.flags.err = (b > 7); end
        13: begin r = ((a >> sh) | (a << (8 - sh))) & 255; o.flags.err = (b > 7); end
        default: legal = 0;
      endcase
    end
    o.res = 16'(r);
    if (!legal || (need_a && !iv[0]) || (need_b && !iv[1])) begin
      o = '0;
      o.flags.err = 1'b1;
    end
    return o;
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, compare after it.
  task automatic step(bit rst, bit ce, bit mode, int cmd, bit [1:0] iv, int a, int b, bit cin);
    int due;
    @(negedge clk);
    RST = rst; CE = ce; MODE = mode; CMD = 4'(cmd); INP_VALID = iv;
    OPA = 8'(a); OPB = 8'(b); CIN = cin;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      exp_out  = '0;
      edge_k   = 0;
      last_due = 0;
    end else if (ce) begin
      edge_k++;
      due = edge_k + ((mode && (cmd == 9 || cmd == 10)) ? 1 : 0);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{due: due, o: ref_model(mode, cmd, iv, a, b, cin)});
      if (pend.size() > 0 && pend[0].due == edge_k) exp_out = pend.pop_front().o;
    end
    #1;
    txn++;
    $display("txn %0d rst=%0b ce=%0b mode=%0b cmd=%0d iv=%b a=%h b=%h cin=%0b -> res=%h c=%0b o=%0b g=%0b e=%0b l=%0b err=%0b",
             txn, rst, ce, mode, cmd, iv, a[7:0], b[7:0], cin, RES, COUT, OFLOW, G, E, L, ERR);
    check_eq("model_out", 32'({RES, COUT, OFLOW, G, E, L, ERR}), 32'(exp_out));
  endtask

  initial begin
    RST = 1'b1; CE = 1'b0; MODE = 1'b0; CMD = '0; INP_VALID = '0;
    OPA = '0; OPB = '0; CIN = 1'b0;

    // Reset with random inputs clears every output.
    step(1, 1, 1'($urandom), $urandom_range(0, 15), 2'($urandom),
         $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
    check_eq("rst_all", 32'({RES, COUT, OFLOW, G, E, L, ERR}), 32'h0);

    step(0, 1, 1, 0, 2'b11, 8'h05, 8'h03, 0);
    check_eq("add_res", 32'(RES), 32'h8);
    check_eq("add_cout", 32'(COUT), 32'h0);
    step(0, 1, 1, 0, 2'b11, 8'hFF, 8'h01, 0);
    check_eq("add_carry_res", 32'(RES), 32'h100);
    check_eq("add_carry_cout", 32'(COUT), 32'h1);
    step(0, 1, 1, 1, 2'b11, 8'h03, 8'h05, 0);
    check_eq("sub_res", 32'(RES), 32'hFFFE);
    check_eq("sub_borrow", 32'(OFLOW), 32'h1);
    step(0, 1, 1, 2, 2'b11, 8'h10, 8'h20, 1);
    check_eq("addcin_res", 32'(RES), 32'h31);
    step(0, 1, 1, 8, 2'b11, 8'h40, 8'h20, 0);
    check_eq("cmp_gel", 32'({G, E, L}), 32'b100);
    check_eq("cmp_res", 32'(RES), 32'h0);
    step(0, 1, 1, 11, 2'b11, 8'h7F, 8'h01, 0);
    check_eq("sadd_oflow", 32'(OFLOW), 32'h1);

    // Multiply: outputs hold one cycle, then the product; a following
    // non-multiply lands one cycle behind it.
    step(0, 1, 1, 9, 2'b11, 2, 3, 0);
    check_eq("mul_hold", 32'(RES), 32'h080);
    step(0, 1, 1, 10, 2'b11, 8'h81, 2, 0);
    check_eq("mulinc_res", 32'(RES), 32'd12);
    step(0, 1, 1, 8, 2'b11, 1, 1, 0);
    check_eq("mulshl_res", 32'(RES), 32'd4);
    step(0, 1, 1, 0, 2'b11, 0, 0, 0);
    check_eq("after_mul_cmp_e", 32'({G, E, L}), 32'b010);

    step(1, 1, 0, 0, 2'b00, 0, 0, 0);
    step(0, 1, 0, 1, 2'b11, 8'hF0, 8'hFF, 0);
    check_eq("nand_res", 32'(RES), 32'h0F);
    step(0, 1, 0, 12, 2'b11, 8'h81, 1, 0);
    check_eq("rol_res", 32'(RES), 32'h03);
    step(0, 1, 0, 13, 2'b11, 8'h5A, 8'h10, 0);
    check_eq("ror_range_err", 32'(ERR), 32'h1);
    check_eq("ror_range_res", 32'(RES), 32'h5A);
    step(0, 1, 1, 0, 2'b01, 8'h12, 8'h34, 0);
    check_eq("add_missing_b_err", 32'(ERR), 32'h1);
    check_eq("add_missing_b_res", 32'(RES), 32'h0);
    step(0, 1, 0, 15, 2'b11, 8'h12, 8'h34, 0);
    check_eq("logic_ill_err", 32'(ERR), 32'h1);

    // Clock enable low: changing inputs are ignored.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 2'b11, $urandom_range(1, 255), $urandom_range(1, 255), 0);
      check_eq("ce_hold_err", 32'(ERR), 32'h1);
      check_eq("ce_hold_res", 32'(RES), 32'h0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, 1'($urandom),
           $urandom_range(0, 15),
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11,
           $urandom_range(0, 255),
           ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255),
           1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
